// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. Synchronises the asynchronous RX pin and
// validates the start bit at mid-bit. It then samples eight data bits
// LSB-first and checks the stop bit.
//
// Output strobes: rx_valid is a one-cycle pulse with no ready/backpressure.
// rx_data changes only in the rx_valid cycle and holds until the next good
// byte. rx_frame_err is a one-cycle pulse for a low stop bit. It never
// coincides with rx_valid and leaves rx_data untouched.
module uart_rx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int N    = CLK_FREQ / BAUD;
  localparam int HALF = N / 2;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          rx_s_q, rx_s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  // State register: FSM, bit timer, shifter, output strobes and the
  // two-flop pin synchroniser (idles high so reset never looks like a start).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      rx_s_q  <= rx_s_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic: every decision looks at the synchronised rx_s only.
  always_comb begin
    sync1_d = uart_rx_pin;
    rx_s_d  = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          // A start bit that is high again at mid-bit was only a glitch.
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          sh_d  = {rx_s_q, sh_q[7:1]};
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = sh_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_HIGH: begin
        // A held-low (break) line must not be re-framed as new bytes.
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: registered strobes and data, busy whenever not idle.
  always_comb begin
    rx_data      = data_q;
    rx_valid     = valid_q;
    rx_frame_err = ferr_q;
    rx_busy      = (state_q != S_IDLE);
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

8N1 UART receiver that recovers bytes from the serial line driven by the team's UART transmitter core. It synchronises the asynchronous RX pin, validates the start bit at mid-bit, samples eight data bits LSB-first, and checks the stop bit. Each good byte is presented for one clock with a valid strobe; a bad stop bit is reported on a separate error strobe. The block sits beside the transmitter in the UART core, and its parameters match the transmitter's so the two ends share a baud rate.

## Interface
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- Derived constants:
  - N = CLK_FREQ/BAUD, integer division. This is 868 at the defaults.
  - HALF = N/2. This is 434 at the defaults.
- clk  in  1  system clock; all state is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- uart_rx_pin  in  1  serial input. It is asynchronous to clk and idles high.
- rx_data  out  8  last good received byte. Holds its value until the next good byte.
- rx_valid  out  1  one-cycle pulse; rx_data is new in the same cycle.
- rx_frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- rx_busy  out  1  high in every state except IDLE.

## Operation
- Input synchroniser:
  - Two flops, both reset to 1. The output is rx_s.
  - All FSM decisions use rx_s only.
- A single bit-timer counter, cnt, counts up to N-1. A bit index, idx, ranges 0..7. A shift register, sh, is 8 bits wide.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - rx_s==0 → START, cnt=0.
- START:
  - At cnt==HALF-1, sample rx_s.
  - If rx_s==0 → DATA, with cnt=0 and idx=0.
  - If rx_s==1 → IDLE. The low pulse is treated as a glitch: no strobe, rx_data unchanged.
- DATA:
  - At cnt==N-1, shift rx_s in LSB-first, i.e. sh = {rx_s, sh[7:1]}, and reset cnt to 0.
  - If idx==7 → STOP; otherwise idx+1.
- STOP:
  - At cnt==N-1, sample rx_s.
  - If rx_s==1: rx_data<=sh, pulse rx_valid → IDLE.
  - If rx_s==0: pulse rx_frame_err, leave rx_data unchanged → WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rx_s==1, then → IDLE.
  - This keeps a held-low line (break) from producing repeated frames.
- Reset values:
  - State IDLE; cnt, idx and sh 0.
  - Outputs: rx_data 8'h00, rx_valid 0, rx_frame_err 0, rx_busy 0.
- Reset mid-frame:
  - The partial byte is discarded and no strobe is produced.
  - After rst deasserts, the block returns to IDLE.
  - If the line is still low at that point (mid-frame), this counts as a new start. The block rejects it or mis-frames it exactly as the FSM rules above dictate. No special handling.
- rx_valid and rx_frame_err are never high in the same cycle.
- There is no backpressure. The consumer must capture rx_data during the rx_valid cycle or before the next byte completes.

## Timing
- Cycle t0 is the first clk edge at which rx_s==0 is seen in IDLE.
- Pin-to-rx_s latency is 2 clk cycles.
- Start bit is sampled at t0+HALF.
- Data bit i is sampled at t0+HALF+(i+1)·N, for i = 0..7.
- Stop bit is sampled at t0+HALF+9·N. rx_valid or rx_frame_err is registered high on the following edge, for exactly 1 cycle.
- At the defaults, the byte is reported ≈ 9.5 bit periods (≈ 82.5 µs) after the start edge.
- The FSM is back in IDLE before the stop bit ends, so back-to-back frames with no idle gap are received.
- rx_busy is high from t0+1 until the cycle the FSM re-enters IDLE.
- Tolerated baud mismatch is ±(HALF/(9.5·N)) ≈ ±5 %.

## Test plan
- Line held idle after reset (bench drives rst low after 100 ns) → outputs stay at reset values, and rx_busy stays 0 for 200 µs.
- Drive frame 0x41 at 8680 ns/bit: start, 1,0,0,0,0,0,1,0, stop → a single rx_valid pulse with rx_data==8'h41, 9.5±0.1 bit periods after the start edge. rx_frame_err stays 0.
- Drive 0x00, 0xFF and 0xA5 back-to-back with no idle gap → three rx_valid pulses with data 00, FF, A5 in order, spaced N·10 cycles apart.
- 200 ns low glitch on an idle line → START rejects it and returns to IDLE. No strobe; rx_data unchanged.
- Frame 0x55 with the stop bit driven low, then the line held low for 3 bit times, then released → one rx_frame_err pulse and no rx_valid. rx_data keeps its previous value, and no further strobes occur while the line is low. A following 0x41 frame is then received correctly.
- Assert rst during bit 4 of a 0x3C frame, release after 100 ns, then send 0x41 after ≥ 1 idle bit time → no strobe for the aborted frame; rx_data==8'h41 with one rx_valid.
